// File: rtl/rgb_pkg.sv
// rgb_pkg: shared palette, FSM state encoding and level-scaling function for RGB colour sources
package rgb_pkg;
  localparam int NUM_COLORS = 6;
  localparam logic [7:0] PAL_R [0:NUM_COLORS-1] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
  localparam logic [7:0] PAL_G [0:NUM_COLORS-1] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
  localparam logic [7:0] PAL_B [0:NUM_COLORS-1] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
  typedef enum logic [2:0] {IDLE, RISE, HOLD, FALL, NEXT} state_e;
  // (c*L + c) >> 8 maps full scale to full scale and zero level to zero without a divider
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] l);
    logic [15:0] p;
    p = 16'(c) * 16'(l) + 16'(c);
    return p[15:8];
  endfunction
endpackage

// File: rtl/rgb_tick_gen.sv
// rgb_tick_gen: fade tick prescaler; clk, rst (async active-low), en in -> tick (one clk per TICK_DIV enabled clks)
module rgb_tick_gen #(
  parameter int TICK_DIV = 1250000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = en && (cnt_q == W'(TICK_DIV - 1));
    cnt_d = !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: palette fade FSM producing six registered 8-bit PWM on-times for two RGB LEDs
// Ports: clk, rst (async active-low), en (run/freeze), mode (0 auto, 1 manual), adv (manual advance pulse)
//        -> R1/G1/B1_time_out (LED1), R2/G2/B2_time_out (LED2 crossfade), color_idx, busy (RISE/FALL)
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter int TICK_DIV   = 1250000,
  parameter int STEP       = 4,
  parameter int HOLD_TICKS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic       adv,
  output logic [7:0] R1_time_out,
  output logic [7:0] G1_time_out,
  output logic [7:0] B1_time_out,
  output logic [7:0] R2_time_out,
  output logic [7:0] G2_time_out,
  output logic [7:0] B2_time_out,
  output logic [2:0] color_idx,
  output logic       busy
);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HT = HW'(HOLD_TICKS);
  localparam logic [7:0] S8 = 8'(STEP);
  state_e state_q, state_d;
  logic [7:0] lvl_q, lvl_d;
  logic [2:0] idx_q, idx_d, nidx;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0] out_q [6];
  logic [7:0] out_d [6];
  logic [2:0] cidx_q;
  logic [8:0] up;
  logic tick;

  rgb_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .en(en), .tick(tick));

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    nidx    = (idx_q == 3'(NUM_COLORS - 1)) ? 3'd0 : idx_q + 3'd1;
    up      = {1'b0, lvl_q} + 9'(STEP);
    if (en)
      case (state_q)
        IDLE: state_d = RISE;
        RISE: if (tick) begin
          lvl_d   = (up >= 9'd255) ? 8'hFF : up[7:0];
          state_d = (up >= 9'd255) ? HOLD : RISE;
        end
        // hold_q == HT means expiry already happened in manual mode; mode and adv are re-sampled every clk
        HOLD: if (hold_q == HT) begin
          if (!mode || adv) begin
            state_d = FALL;
            hold_d  = '0;
          end
        end else if (tick) begin
          hold_d  = (hold_q + 1'b1 == HT && !mode) ? '0 : hold_q + 1'b1;
          state_d = (hold_q + 1'b1 == HT && !mode) ? FALL : HOLD;
        end
        FALL: if (tick) begin
          lvl_d   = (lvl_q <= S8) ? 8'd0 : lvl_q - S8;
          state_d = (lvl_q <= S8) ? NEXT : FALL;
        end
        NEXT: begin
          idx_d   = nidx;
          state_d = RISE;
        end
        default: state_d = IDLE;
      endcase
    out_d[0] = scale(PAL_R[idx_q], lvl_q);
    out_d[1] = scale(PAL_G[idx_q], lvl_q);
    out_d[2] = scale(PAL_B[idx_q], lvl_q);
    out_d[3] = scale(PAL_R[nidx], ~lvl_q);
    out_d[4] = scale(PAL_G[nidx], ~lvl_q);
    out_d[5] = scale(PAL_B[nidx], ~lvl_q);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      cidx_q  <= '0;
      for (int i = 0; i < 6; i++) out_q[i] <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      cidx_q  <= idx_q;
      for (int i = 0; i < 6; i++) out_q[i] <= out_d[i];
    end

  assign R1_time_out = out_q[0];
  assign G1_time_out = out_q[1];
  assign B1_time_out = out_q[2];
  assign R2_time_out = out_q[3];
  assign G2_time_out = out_q[4];
  assign B2_time_out = out_q[5];
  assign color_idx   = cidx_q;
  assign busy        = (state_q == RISE) || (state_q == FALL);
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: directed checks of fade sequencing, wrap, manual advance, freeze and async reset
module tb_rgb_fade_sequencer;
  logic clk = 1'b0;
  logic rst, en, mode, adv;
  logic [7:0] r1, g1, b1, r2, g2, b2;
  logic [2:0] cidx;
  logic busy;
  int npass = 0;
  int ntot = 0;
  int e = 0;

  rgb_fade_sequencer #(.TICK_DIV(2), .STEP(64), .HOLD_TICKS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .adv(adv),
    .R1_time_out(r1), .G1_time_out(g1), .B1_time_out(b1),
    .R2_time_out(r2), .G2_time_out(g2), .B2_time_out(b2),
    .color_idx(cidx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_leds(input string tag, input logic [47:0] exp);
    chk(tag, {r1, g1, b1, r2, g2, b2}, exp);
  endtask

  // advance to 2 time units after rising edge number k (counted from reset release)
  task automatic goto(input int k);
    repeat (k - e) @(posedge clk);
    #2;
    e = k;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; mode = 1'b0; adv = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_leds("reset_leds", 48'h0);
    chk("reset_idx", 48'(cidx), 48'd0);
    chk("reset_busy", 48'(busy), 48'd0);
    rst = 1'b1;
    goto(1);
    chk("idle_to_rise_busy", 48'(busy), 48'd1);
    goto(5);
    chk_leds("rise_lvl128_idx0", {8'd128, 8'd0, 8'd0, 8'd127, 8'd127, 8'd0});
    goto(7);
    chk("rise_busy_before_hold", 48'(busy), 48'd1);
    goto(8);
    chk("hold_busy_low", 48'(busy), 48'd0);
    goto(9);
    chk_leds("hold_full_idx0", {8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    goto(45);
    chk("idx2_color", 48'(cidx), 48'd2);
    chk_leds("rise_lvl128_idx2", {8'd0, 8'd128, 8'd0, 8'd0, 8'd127, 8'd127});
    goto(105);
    chk_leds("rise_lvl128_idx5", {8'd128, 8'd0, 8'd128, 8'd127, 8'd0, 8'd0});
    goto(121);
    chk("wrap_before", 48'(cidx), 48'd5);
    goto(122);
    chk("wrap_after", 48'(cidx), 48'd0);
    mode = 1'b1;
    adv = 1'b1;
    goto(123);
    adv = 1'b0;
    chk("adv_in_rise_ignored", 48'(busy), 48'd1);
    goto(132);
    chk("manual_hold_past_expiry", 48'(busy), 48'd0);
    goto(140);
    chk("manual_hold_stays", 48'(busy), 48'd0);
    chk_leds("manual_hold_full", {8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    adv = 1'b1;
    goto(141);
    adv = 1'b0;
    mode = 1'b0;
    chk("adv_to_fall", 48'(busy), 48'd1);
    goto(143);
    chk_leds("fall_lvl191", {8'd191, 8'd0, 8'd0, 8'd64, 8'd64, 8'd0});
    goto(152);
    en = 1'b0;
    goto(172);
    chk_leds("freeze_held", {8'd128, 8'd128, 8'd0, 8'd0, 8'd127, 8'd0});
    chk("freeze_busy", 48'(busy), 48'd1);
    en = 1'b1;
    goto(174);
    chk_leds("unfreeze_no_early_step", {8'd128, 8'd128, 8'd0, 8'd0, 8'd127, 8'd0});
    goto(175);
    chk_leds("unfreeze_step192", {8'd192, 8'd192, 8'd0, 8'd0, 8'd63, 8'd0});
    goto(225);
    chk_leds("fall_idx3_lvl127", {8'd0, 8'd127, 8'd127, 8'd0, 8'd0, 8'd128});
    chk("fall_idx3_color", 48'(cidx), 48'd3);
    chk("fall_idx3_busy", 48'(busy), 48'd1);
    #1;
    rst = 1'b0;
    #1;
    chk_leds("async_reset_leds", 48'h0);
    chk("async_reset_idx", 48'(cidx), 48'd0);
    chk("async_reset_busy", 48'(busy), 48'd0);
    #3;
    rst = 1'b1;
    e = 0;
    goto(1);
    chk("restart_busy", 48'(busy), 48'd1);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
